// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting exclusive write access to one shared WIDTH-bit
// register among N_REQ requesters, with each tenure capped at MAX_HOLD writes.
module shared_reg_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     ptr, ptr_nx, owner_nx, winner;
    logic [HW-1:0]     hold, hold_nx;
    logic [N_REQ-1:0]  gnt_nx;
    logic [WIDTH-1:0]  q_nx;
    logic              q_valid_nx;
    logic              found, wr, rel;

    // Rotating search starting at ptr; first set request wins.
    always_comb begin : arbitrate
        int unsigned idx;
        logic [IW-1:0] idx_b;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_b  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx   = (32'(ptr) + k) % N_REQ;
            idx_b = IW'(idx);
            if (!found && req[idx_b]) begin
                found  = 1'b1;
                winner = idx_b;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        owner_nx   = owner;
        ptr_nx     = ptr;
        hold_nx    = hold;
        q_nx       = q;
        q_valid_nx = q_valid;

        wr  = (state == GRANT) && req[owner];
        rel = (state == GRANT) && (!wr || (hold == HW'(MAX_HOLD - 1)));

        if (wr) begin
            q_nx       = wdata[owner*WIDTH +: WIDTH];
            q_valid_nx = 1'b1;
            hold_nx    = hold + 1'b1;
        end

        // A release re-arbitrates in the same edge so the next owner has no idle bubble.
        if (state == IDLE || rel) begin
            if (found) begin
                state_nx         = GRANT;
                gnt_nx           = '0;
                gnt_nx[winner]   = 1'b1;
                owner_nx         = winner;
                ptr_nx           = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                hold_nx          = '0;
            end else begin
                state_nx = IDLE;
                gnt_nx   = '0;
                owner_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            owner   <= '0;
            ptr     <= '0;
            hold    <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            owner   <= owner_nx;
            ptr     <= ptr_nx;
            hold    <= hold_nx;
            q       <= q_nx;
            q_valid <= q_valid_nx;
        end
    end

    assign busy = |gnt;

endmodule
